// File: rtl/fifo_burst_drain_if.sv
// FIFO read port and output stream of fifo_burst_drain, bundled so the
// drain block and its consumer share one connection.
interface fifo_burst_drain_if #(
  parameter int DATA_W = 128
);
  logic              fifo_empty;
  logic              fifo_almost_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_almost_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_almost_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_burst_drain.sv
// Pops words from the upstream FIFO and re-emits them as fixed BURST_LEN bursts
// on a valid/ready stream, through a 2-entry skid buffer.
module fifo_burst_drain #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  fifo_burst_drain_if.master bus,
  output logic               burst_active,
  output logic [31:0]        words_sent
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // One extra bit so a BURST_LEN of 2**CNT_W is still representable.
  localparam logic [CNT_W:0] LP_BURST    = (CNT_W+1)'(BURST_LEN);
  localparam logic [CNT_W:0] LP_LAST_IDX = (CNT_W+1)'(BURST_LEN - 1);
  localparam logic [CNT_W:0] LP_ONE      = (CNT_W+1)'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W:0]    r_rd_cnt;
  logic              w_rd_en;
  logic              w_pop;
  logic              w_last_in;
  logic [1:0]        r_buf_cnt;
  logic [DATA_W-1:0] r_buf_d0;
  logic [DATA_W-1:0] r_buf_d1;
  logic              r_buf_l0;
  logic              r_buf_l1;
  logic              r_burst_active;
  logic [31:0]       r_words_sent;

  assign w_pop     = (r_buf_cnt != 2'd0) & bus.m_ready;
  assign w_last_in = (r_rd_cnt == LP_LAST_IDX);

  // Next-state and FIFO read strobe
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && !bus.fifo_empty && (!bus.fifo_almost_empty || flush)) begin
          w_next_state = S_FILL;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FILL: begin
        w_rd_en = !bus.fifo_empty && (r_buf_cnt < 2'd2) && (r_rd_cnt < LP_BURST);
        if (w_rd_en && w_last_in) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_FILL;
        end
      end
      S_DRAIN: begin
        if (w_pop && r_buf_l0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register and burst-active flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_burst_active <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_burst_active <= (w_next_state != S_IDLE);
    end
  end

  // Beat counter: held at zero while idle so every burst starts from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_rd_cnt <= '0;
    end else if (w_rd_en) begin
      r_rd_cnt <= r_rd_cnt + LP_ONE;
    end
  end

  // Skid buffer; unused slots are kept at zero so the head reads 0 when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_cnt <= 2'd0;
      r_buf_d0  <= {DATA_W{1'b0}};
      r_buf_d1  <= {DATA_W{1'b0}};
      r_buf_l0  <= 1'b0;
      r_buf_l1  <= 1'b0;
    end else begin
      case ({w_rd_en, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf_d0 <= bus.fifo_rd_data;
            r_buf_l0 <= w_last_in;
          end else begin
            r_buf_d1 <= bus.fifo_rd_data;
            r_buf_l1 <= w_last_in;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf_d0  <= r_buf_d1;
          r_buf_l0  <= r_buf_l1;
          r_buf_d1  <= {DATA_W{1'b0}};
          r_buf_l1  <= 1'b0;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf_d0 <= bus.fifo_rd_data;
            r_buf_l0 <= w_last_in;
          end else begin
            r_buf_d0 <= r_buf_d1;
            r_buf_l0 <= r_buf_l1;
            r_buf_d1 <= bus.fifo_rd_data;
            r_buf_l1 <= w_last_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Accepted-word counter, wraps naturally at 2**32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words_sent <= 32'd0;
    end else if (w_pop) begin
      r_words_sent <= r_words_sent + 32'd1;
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = (r_buf_cnt != 2'd0);
  assign bus.m_data     = r_buf_d0;
  assign bus.m_last     = r_buf_l0;
  assign burst_active   = r_burst_active;
  assign words_sent     = r_words_sent;

endmodule
